// File: rtl/lowbit_pkg.sv
// lowbit_pkg: 2-bit activation code constants and encode/decode helpers
package lowbit_pkg;
    localparam logic [1:0] CODE_M3 = 2'b00;
    localparam logic [1:0] CODE_M1 = 2'b01;
    localparam logic [1:0] CODE_P1 = 2'b10;
    localparam logic [1:0] CODE_P3 = 2'b11;
    localparam int PACK_CODES = 16;

    function automatic logic signed [2:0] decode2(input logic [1:0] code);
        return code == CODE_M3 ? -3'sd3 :
               code == CODE_M1 ? -3'sd1 :
               code == CODE_P1 ?  3'sd1 : 3'sd3;
    endfunction

    // Takes a value already saturated to [-4,3]; thresholds sit at -2, 0 and 2.
    function automatic logic [1:0] encode2(input logic signed [3:0] v);
        return v < -4'sd2 ? CODE_M3 :
               v <  4'sd0 ? CODE_M1 :
               v <= 4'sd2 ? CODE_P1 : CODE_P3;
    endfunction
endpackage

// File: rtl/quant_encode2.sv
// quant_encode2: floor-shift an accumulator and map it to a 2-bit activation code
module quant_encode2
    import lowbit_pkg::*;
#(
    parameter int W = 40
) (
    input  logic signed [W-1:0] val,
    input  logic        [4:0]   shift,
    output logic        [1:0]   code
);
    logic signed [W-1:0] v;
    logic signed [3:0]   s;

    always_comb begin
        v = val >>> shift;
        s = v < W'(-4) ? 4'sb1100 : v > W'(3) ? 4'sd3 : v[3:0];
        code = encode2(s);
    end
endmodule

// File: rtl/act_quant_pack.sv
// act_quant_pack: accumulate partials per pixel, requantize to 2-bit codes, pack 16 per word
module act_quant_pack
    import lowbit_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int EXT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cfg_accum_len,
    input  logic [4:0]       cfg_shift,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] partial,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_count,
    output logic             busy
);
    localparam int AW = ACC_W + EXT_W;

    logic [7:0]          bcnt_q, bcnt_d, len_q, len_d, len_eff;
    logic [4:0]          shift_q, shift_d, shift_eff;
    logic signed [AW-1:0] acc_q, acc_d, acc_next;
    logic [31:0]         pack_q, pack_d, pack_w;
    logic [4:0]          pcnt_q, pcnt_d, pcnt_w;
    logic                flush_pend_q, flush_pend_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [4:0]          out_count_q, out_count_d;
    logic                fire, first, last, fp;
    logic [1:0]          code;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign busy      = bcnt_q != 8'd0 || pcnt_q != 5'd0 || flush_pend_q;

    quant_encode2 #(.W(AW)) u_enc (
        .val   (acc_next),
        .shift (shift_eff),
        .code  (code)
    );

    always_comb begin
        fire      = in_valid && in_ready;
        first     = bcnt_q == 8'd0;
        len_eff   = first ? (cfg_accum_len == 8'd0 ? 8'd1 : cfg_accum_len) : len_q;
        shift_eff = first ? cfg_shift : shift_q;
        acc_next  = (first ? '0 : acc_q) + {{EXT_W{partial[ACC_W-1]}}, partial};
        last      = fire && bcnt_q == len_eff - 8'd1;
        pack_w    = last ? pack_q | (32'(code) << {pcnt_q, 1'b0}) : pack_q;
        pcnt_w    = pcnt_q + {4'd0, last};
        fp        = flush_pend_q || flush;
        bcnt_d    = fire ? (last ? 8'd0 : bcnt_q + 8'd1) : bcnt_q;
        acc_d     = fire ? acc_next : acc_q;
        len_d     = fire && first ? len_eff : len_q;
        shift_d   = fire && first ? shift_eff : shift_q;
        pack_d    = pack_w;
        pcnt_d    = pcnt_w;
        flush_pend_d = fp;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        if (pcnt_w == 5'(PACK_CODES)) begin
            out_valid_d = 1'b1;
            out_data_d  = pack_w;
            out_count_d = pcnt_w;
            pack_d      = '0;
            pcnt_d      = '0;
        end
        // A full word already emptied the pack, so a pending flush simply retires.
        if (fp && pcnt_d == 5'd0) begin
            flush_pend_d = 1'b0;
        end else if (fp && in_ready) begin
            out_valid_d  = 1'b1;
            out_data_d   = pack_w;
            out_count_d  = pcnt_w;
            pack_d       = '0;
            pcnt_d       = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q       <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            acc_q        <= '0;
            pack_q       <= '0;
            pcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
        end else begin
            bcnt_q       <= bcnt_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            pack_q       <= pack_d;
            pcnt_q       <= pcnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
        end
    end
endmodule

// File: tb/tb_act_quant_pack.sv
// tb_act_quant_pack: directed and random checks against a pixel/word level reference model
module tb_act_quant_pack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cfg_accum_len = 8'd1;
    logic [4:0]  cfg_shift = 5'd0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] partial = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_count;
    logic        busy;

    int total = 0;
    int bad = 0;

    int      m_bcnt, m_len, m_sh;
    longint  m_sum;
    bit      m_pend;
    int      codes[$];
    logic [36:0] expq[$];

    always #5 clk = ~clk;

    act_quant_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_accum_len (cfg_accum_len),
        .cfg_shift     (cfg_shift),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .partial       (partial),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_count     (out_count),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint floordiv(input longint s, input int sh);
        longint d = 1;
        longint q;
        repeat (sh) d = d * 2;
        q = s / d;
        if (s % d != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int enc(input longint v);
        if (v < -2) return 0;
        if (v < 0) return 1;
        if (v <= 2) return 2;
        return 3;
    endfunction

    task automatic emit_word();
        logic [31:0] w = '0;
        foreach (codes[k]) w = w | (32'(codes[k]) << (2 * k));
        expq.push_back({5'(codes.size()), w});
        codes.delete();
    endtask

    task automatic model_reset();
        m_bcnt = 0;
        m_sum = 0;
        m_pend = 0;
        codes.delete();
        expq.delete();
    endtask

    task automatic model_step(input bit took, input int p, input bit f, input bit can_load);
        if (took) begin
            if (m_bcnt == 0) begin
                m_len = cfg_accum_len == 0 ? 1 : int'(cfg_accum_len);
                m_sh = int'(cfg_shift);
                m_sum = 0;
            end
            m_sum += p;
            m_bcnt++;
            if (m_bcnt == m_len) begin
                codes.push_back(enc(floordiv(m_sum, m_sh)));
                m_bcnt = 0;
            end
        end
        if (f) m_pend = 1;
        if (codes.size() == 16) emit_word();
        if (m_pend && codes.size() == 0) m_pend = 0;
        else if (m_pend && can_load) begin
            emit_word();
            m_pend = 0;
        end
    endtask

    task automatic cycle(input bit v, input int p, input bit f, input bit ordy, output bit took);
        logic [36:0] e;
        in_valid = v;
        partial = 32'(p);
        flush = f;
        out_ready = ordy;
        #1;
        took = v && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("extra_word", 1, 0);
            else begin
                e = expq.pop_front();
                chk("word", out_data, e[31:0]);
                chk("count", out_count, e[36:32]);
            end
        end
        model_step(took, p, f, in_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit t;
        repeat (n) cycle(0, 0, 0, ordy, t);
    endtask

    task automatic send(input int p, input bit f, input bit ordy);
        bit t;
        int n = 0;
        do begin
            cycle(1, p, f, ordy, t);
            n++;
        end while (!t && n < 50);
        if (!t) chk("send_timeout", 0, 1);
    endtask

    task automatic do_reset();
        in_valid = 0;
        flush = 0;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        bit t;
        logic [31:0] held;
        model_reset();
        @(negedge clk);
        do_reset();

        cfg_accum_len = 1; cfg_shift = 0;
        repeat (16) send(5, 0, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'hFFFF_FFFF);
        chk("t1_count", out_count, 16);
        chk("t1_busy", busy, 0);
        idle(1, 1);
        chk("t1_drained", out_valid, 0);

        for (int i = -3; i <= 3; i++) send(i, 0, 1);
        cycle(0, 0, 1, 1, t);
        chk("t2_data", out_data, 32'h0000_3A94);
        chk("t2_count", out_count, 7);
        idle(1, 1);

        cfg_accum_len = 3; cfg_shift = 2;
        send(4, 0, 1); send(4, 0, 1); send(4, 0, 1);
        send(-4, 0, 1); send(-4, 0, 1); send(-5, 0, 1);
        cycle(0, 0, 1, 1, t);
        chk("t3_data", out_data, 32'h0000_0003);
        chk("t3_count", out_count, 2);
        idle(1, 1);

        cfg_accum_len = 0; cfg_shift = 0;
        repeat (16) send(5, 0, 0);
        held = out_data;
        chk("bp_in_ready", in_ready, 0);
        idle(3, 0);
        chk("bp_stable", out_data, held);
        chk("bp_valid", out_valid, 1);
        cycle(1, -9, 0, 0, t);
        chk("bp_no_accept", t, 0);
        repeat (16) send(-9, 0, 1);
        chk("bp2_data", out_data, 32'h0000_0000);
        chk("bp2_count", out_count, 16);
        idle(1, 1);

        cycle(0, 0, 1, 1, t);
        chk("ef_valid", out_valid, 0);
        chk("ef_busy", busy, 0);
        repeat (15) send(1, 0, 1);
        send(1, 1, 1);
        chk("f16_count", out_count, 16);
        idle(2, 1);
        chk("f16_once", out_valid, 0);
        chk("f16_busy", busy, 0);

        repeat (5) send(1, 0, 1);
        chk("mid_busy", busy, 1);
        do_reset();
        cfg_accum_len = 1; cfg_shift = 0;
        repeat (16) send(1, 0, 1);
        chk("rr_data", out_data, 32'hAAAA_AAAA);
        chk("rr_count", out_count, 16);
        idle(1, 1);

        for (int i = 0; i < 3000; i++) begin
            cfg_accum_len = 8'($urandom_range(0, 4));
            cfg_shift = 5'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 40)) - 20,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, t);
        end
        cycle(0, 0, 1, 1, t);
        idle(5, 1);
        chk("leftover", 64'(expq.size()), 0);
        chk("end_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
